// File: rtl/imem_fetch_responder_if.sv
// Fetch-side and refill-side signal bundle for imem_fetch_responder.
//
// Handshake rules for the refill side: the responder raises mem_req with a
// line-aligned mem_addr and keeps both stable until the first cycle in which
// mem_ack is high. That cycle is the transfer. After the transfer, the memory
// returns LINE_WORDS beats in ascending word order, each marked by mem_rvalid.
// Beats cannot be back-pressured.
//
// Signals:
//   if_addr, hold, inv      fetch PC, downstream freeze, invalidate-all
//   id_inst, fetch_stall    instruction word to ID, "not serviceable" flag
//   mem_req, mem_addr       refill request and line address
//   mem_ack, mem_rvalid,
//   mem_rdata               refill accept, beat valid, beat data
//   dbg_state               responder FSM state (0 IDLE, 1 REQ, 2 FILL)
//   hit_count, miss_count   present only when ICACHE_STATS_EN is defined
interface imem_fetch_responder_if;
  logic [31:0] if_addr;
  logic        hold;
  logic        inv;
  logic [31:0] id_inst;
  logic        fetch_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  if_addr, hold, inv, mem_ack, mem_rvalid, mem_rdata,
    output id_inst, fetch_stall, mem_req, mem_addr, dbg_state,
           hit_count, miss_count
  );
  modport master (
    output if_addr, hold, inv, mem_ack, mem_rvalid, mem_rdata,
    input  id_inst, fetch_stall, mem_req, mem_addr, dbg_state,
           hit_count, miss_count
  );
`else
  modport slave (
    input  if_addr, hold, inv, mem_ack, mem_rvalid, mem_rdata,
    output id_inst, fetch_stall, mem_req, mem_addr, dbg_state
  );
  modport master (
    output if_addr, hold, inv, mem_ack, mem_rvalid, mem_rdata,
    input  id_inst, fetch_stall, mem_req, mem_addr, dbg_state
  );
`endif
endinterface

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: a direct-mapped instruction cache that answers IF-stage
// fetch addresses. On a hit, it delivers the word to ID after one cycle.
// On a miss, it raises fetch_stall and refills one line from backing memory
// using a req/ack handshake followed by a beat burst.
//
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    imem_fetch_responder_if.slave (fetch side + refill side + dbg_state)
//
// Parameters: NUM_LINES (power of 2, >= 2), LINE_WORDS (power of 2, >= 2).
// Optional feature macro: ICACHE_STATS_EN. When it is defined, the block adds
// the hit_count and miss_count counters to the interface.
module imem_fetch_responder #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  imem_fetch_responder_if.slave   bus
);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = 30 - OFF_W - IDX_W;
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   inv_pend_q, inv_pend_d;
  logic                   mem_req_q, mem_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            id_inst_q, id_inst_d;

  // Data and tag storage are not reset. The valid bits alone decide whether
  // the contents mean anything.
  logic [31:0]            line_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];

  logic [TAG_W-1:0]       lk_tag;
  logic [IDX_W-1:0]       lk_idx;
  logic [OFF_W-1:0]       lk_off;
  logic [TAG_W-1:0]       fill_tag;
  logic [IDX_W-1:0]       fill_idx;
  logic                   hit;
  logic                   beat_we;
  logic                   last_beat;
  logic                   unused_addr_bits;

  assign lk_tag   = bus.if_addr[31:TAG_LSB];
  assign lk_idx   = bus.if_addr[TAG_LSB-1:IDX_LSB];
  assign lk_off   = bus.if_addr[IDX_LSB-1:2];
  // The line being refilled is identified by the latched request address.
  // If if_addr is redirected mid-burst, the refill still targets the original line.
  assign fill_tag = mem_addr_q[31:TAG_LSB];
  assign fill_idx = mem_addr_q[TAG_LSB-1:IDX_LSB];
  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign hit       = (state_q == S_IDLE) && valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign beat_we   = (state_q == S_FILL) && bus.mem_rvalid;
  assign last_beat = beat_we && (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    id_inst_d  = id_inst_q;

    if (!bus.hold) begin
      id_inst_d = hit ? line_mem[{lk_idx, lk_off}] : NOP;
    end

    case (state_q)
      S_IDLE: begin
        // The invalidate takes effect at the edge. The lookup in this cycle
        // has already been resolved against the old valid bits.
        if (bus.inv) valid_d = '0;
        if (!hit) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = {lk_tag, lk_idx, {(OFF_W+2){1'b0}}};
        end
      end
      S_REQ: begin
        if (bus.inv) inv_pend_d = 1'b1;
        if (bus.mem_ack) begin
          state_d   = S_FILL;
          mem_req_d = 1'b0;
        end
      end
      S_FILL: begin
        if (bus.inv) inv_pend_d = 1'b1;
        if (beat_we) cnt_d = cnt_q + 1'b1;  // wraps to 0 on the last beat
        if (last_beat) begin
          state_d    = S_IDLE;
          inv_pend_d = 1'b0;
          // An invalidate that arrived during the refill also wipes the
          // line being installed. Without this, the fetch after fence.i
          // could read stale code.
          if (inv_pend_q || bus.inv) valid_d = '0;
          else                       valid_d[fill_idx] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      id_inst_q  <= NOP;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      id_inst_q  <= id_inst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we)   line_mem[{fill_idx, cnt_q}] <= bus.mem_rdata;
    if (last_beat) tag_mem[fill_idx]           <= fill_tag;
  end

  assign bus.id_inst     = id_inst_q;
  assign bus.fetch_stall = !hit;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.dbg_state   = state_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && !bus.hold)               hit_count_d  = hit_count_q + 32'd1;
    if ((state_q == S_IDLE) && !hit)    miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
`endif
endmodule
